uart_rx_ctrl: RTL

Receive-side frame sequencer for the UART RX path. It detects the start bit on the synchronized `i_rx` line and samples each bit at its mid-point using the oversample enable. It shifts in `DATA_BITS` data bits LSB-first, checks `STOP_BITS` stop bits, and presents the completed byte with frame status through a valid/ack handshake. It sits between the RX line synchronizer / oversample tick generator and the byte consumer (FIFO or CPU I/O port), replacing ad-hoc chaining of the per-field bit counters.

---
 rtl/uart_rx_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer with mid-bit sampling, stop check and valid/ack output.
// Define UART_RX_PARITY_EN to add the PARITY state and the o_parity_err port.
module uart_rx_ctrl #(
  parameter int OSR        = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_rx,
  input  logic                 i_ack,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic                 o_busy
);
  localparam int CW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS + 1);
  if (OSR < 4 || OSR % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_ctrl: parameter out of range");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_BITS-1:0]  r_shift, r_data;
  logic                  r_ferr, r_valid, r_frame_err, r_overrun;
  logic                  w_mid, w_end, w_last_data, w_last_stop;
  logic                  w_shift, w_stop_smp, w_commit, w_take;
  assign w_mid       = r_cnt == CW'(OSR/2 - 1);
  assign w_end       = r_cnt == CW'(OSR - 1);
  assign w_last_data = r_bit == BW'(DATA_BITS - 1);
  assign w_last_stop = r_bit == BW'(STOP_BITS - 1);
  always_ff @(posedge i_clk)
    r_state <= i_rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (i_en)
      case (r_state)
        S_IDLE:   w_next = i_rx ? S_IDLE : S_START;
        S_START:  w_next = !w_mid ? S_START : (i_rx ? S_IDLE : S_DATA);
        S_DATA:   w_next = (w_end && w_last_data) ? S_AFTER_DATA : S_DATA;
`ifdef UART_RX_PARITY_EN
        S_PARITY: w_next = w_end ? S_STOP : S_PARITY;
`endif
        S_STOP:   w_next = (w_end && w_last_stop) ? S_IDLE : S_STOP;
        default:  w_next = S_IDLE;
      endcase
  end
  always_comb begin
    o_busy     = r_state != S_IDLE;
    w_shift    = i_en && w_end && r_state == S_DATA;
    w_stop_smp = i_en && w_end && r_state == S_STOP;
    w_commit   = w_stop_smp && w_last_stop;
    w_take     = i_ack && r_valid;
  end
  // counters restart on every state change so each field is timed from its own entry
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_cnt <= '0;
        r_bit <= '0;
      end else if (i_en && r_state != S_IDLE) begin
        r_cnt <= w_end ? '0 : r_cnt + 1'b1;
        if (w_shift || w_stop_smp)
          r_bit <= r_bit + 1'b1;
      end
      if (w_shift)
        r_shift <= {i_rx, r_shift[DATA_BITS-1:1]};
      r_ferr <= (r_state == S_STOP) && (r_ferr || (w_stop_smp && !i_rx));
    end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_data      <= r_shift;
        r_frame_err <= r_ferr || !i_rx;
      end
      r_valid   <= w_commit || (r_valid && !i_ack);
      r_overrun <= (r_overrun && !w_take) || (w_commit && r_valid && !i_ack);
    end
`ifdef UART_RX_PARITY_EN
  logic r_par_err, r_parity_err;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_par_err    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (i_en && w_end && r_state == S_PARITY)
        r_par_err <= (^r_shift ^ i_rx) != 1'(PARITY_ODD);
      if (w_commit)
        r_parity_err <= r_par_err;
    end
  assign o_parity_err = r_parity_err;
`endif
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
endmodule
